// File: rtl/int_priority_ctrl_if.sv
// int_priority_ctrl_if: device request, mask/priority/vector and INT/INTV handshake bundle
interface int_priority_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int PRI_W = 3,
  parameter int VEC_W = 8
);
  logic [NUM_SRC-1:0]       irq_in;
  logic [NUM_SRC-1:0]       src_en;
  logic [NUM_SRC*PRI_W-1:0] src_pri;
  logic [NUM_SRC*VEC_W-1:0] src_vec;
  logic [PRI_W-1:0]         cur_pri;
  logic                     int_ack;
  logic                     INT;
  logic [VEC_W-1:0]         INTV;
  logic [PRI_W-1:0]         int_pri;
  logic [NUM_SRC-1:0]       pend;
  modport master (
    output irq_in, src_en, src_pri, src_vec, cur_pri, int_ack,
    input  INT, INTV, int_pri, pend
  );
  modport slave (
    input  irq_in, src_en, src_pri, src_vec, cur_pri, int_ack,
    output INT, INTV, int_pri, pend
  );
endinterface

// File: rtl/int_priority_ctrl.sv
// int_priority_ctrl: edge-captured sticky pending bits, priority pick vs PSR, INT/INTV held until ack
module int_priority_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int PRI_W = 3,
  parameter int VEC_W = 8
) (
  input logic clk,
  input logic reset,
  int_priority_ctrl_if.slave bus
);
  localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_SRC-1:0] pend_q, pend_d, irq_q, clr;
  logic               int_q, int_d;
  logic [VEC_W-1:0]   intv_q, intv_d;
  logic [PRI_W-1:0]   int_pri_q, int_pri_d;
  logic               win_found, win_valid;
  logic [SEL_W-1:0]   win_idx;
  logic [PRI_W-1:0]   win_pri;
  logic [VEC_W-1:0]   win_vec;
  // strict > keeps the lowest index on priority ties
  always_comb begin
    win_found = 1'b0;
    win_idx = '0;
    win_pri = '0;
    win_vec = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (pend_q[i] && bus.src_en[i] && (!win_found || bus.src_pri[i*PRI_W +: PRI_W] > win_pri)) begin
        win_found = 1'b1;
        win_idx = SEL_W'(i);
        win_pri = bus.src_pri[i*PRI_W +: PRI_W];
        win_vec = bus.src_vec[i*VEC_W +: VEC_W];
      end
    win_valid = win_found && win_pri > bus.cur_pri;
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    int_d = int_q;
    intv_d = intv_q;
    int_pri_d = int_pri_q;
    clr = '0;
    case (state_q)
      IDLE: if (win_valid) begin
        state_d = ASSERT;
        sel_d = win_idx;
        int_d = 1'b1;
        intv_d = win_vec;
        int_pri_d = win_pri;
      end
      ASSERT: if (bus.int_ack) begin
        clr = NUM_SRC'(1) << sel_q;
        int_d = 1'b0;
        state_d = HOLD;
      end else if (!bus.src_en[sel_q] || bus.cur_pri >= int_pri_q) begin
        int_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        int_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    // a fresh edge on the acknowledged source survives the clear
    pend_d = (pend_q & ~clr) | (bus.irq_in & ~irq_q & bus.src_en);
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      sel_q <= '0;
      pend_q <= '0;
      irq_q <= '1;
      int_q <= 1'b0;
      intv_q <= '0;
      int_pri_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      pend_q <= pend_d;
      irq_q <= bus.irq_in;
      int_q <= int_d;
      intv_q <= intv_d;
      int_pri_q <= int_pri_d;
    end
  assign bus.INT = int_q;
  assign bus.INTV = intv_q;
  assign bus.int_pri = int_pri_q;
  assign bus.pend = pend_q;
endmodule

// File: tb/tb_int_priority_ctrl.sv
// tb_int_priority_ctrl: directed scenarios plus random traffic, scoreboarded against a behavioural model
module tb_int_priority_ctrl;
  localparam int N = 4, PW = 3, VW = 8;
  logic clk = 1'b0;
  logic reset;
  int_priority_ctrl_if #(.NUM_SRC(N), .PRI_W(PW), .VEC_W(VW)) bus ();
  int_priority_ctrl #(.NUM_SRC(N), .PRI_W(PW), .VEC_W(VW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [PW+VW-1:0] exp_q[$];
  // model: outstanding interrupt presentation; phase 0 = none, 1 = presenting, 2 = one-cycle gap after ack
  bit m_pend[N];
  bit m_prev[N];
  int m_phase, m_sel, m_pri;
  bit m_int;
  logic [N-1:0] m_pend_v;
  function automatic int pri_of(int i);
    return int'(bus.src_pri[i*PW +: PW]);
  endfunction
  function automatic logic [VW-1:0] vec_of(int i);
    return bus.src_vec[i*VW +: VW];
  endfunction
  task automatic model_step();
    int best, clear;
    bit rise[N];
    if (reset) begin
      foreach (m_pend[i]) begin m_pend[i] = 0; m_prev[i] = 1; end
      m_phase = 0; m_int = 0; m_pri = 0; m_sel = 0;
    end else begin
      best = -1; clear = -1;
      for (int i = 0; i < N; i++) begin
        rise[i] = bus.irq_in[i] && !m_prev[i] && bus.src_en[i];
        if (m_pend[i] && bus.src_en[i] && (best < 0 || pri_of(i) > pri_of(best))) best = i;
      end
      if (m_phase == 0) begin
        if (best >= 0 && pri_of(best) > int'(bus.cur_pri)) begin
          m_phase = 1; m_int = 1; m_sel = best; m_pri = pri_of(best);
          exp_q.push_back({PW'(m_pri), vec_of(best)});
        end
      end else if (m_phase == 1) begin
        if (bus.int_ack) begin clear = m_sel; m_int = 0; m_phase = 2; end
        else if (!bus.src_en[m_sel] || int'(bus.cur_pri) >= m_pri) begin m_int = 0; m_phase = 0; end
      end else m_phase = 0;
      if (clear >= 0) m_pend[clear] = 0;
      for (int i = 0; i < N; i++) begin
        if (rise[i]) m_pend[i] = 1;
        m_prev[i] = bus.irq_in[i];
      end
    end
    foreach (m_pend[i]) m_pend_v[i] = m_pend[i];
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask
  task automatic ack();
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
  endtask
  task automatic set_src(int i, int p, int v);
    bus.src_pri[i*PW +: PW] = PW'(p);
    bus.src_vec[i*VW +: VW] = VW'(v);
  endtask
  // monitor: per-cycle INT/pend, and popped vector/priority whenever INT is newly presented
  logic int_prev = 1'b0;
  logic [PW+VW-1:0] e;
  always @(negedge clk) begin
    checks++;
    if (bus.INT !== m_int) begin errors++; $display("FAIL int: got %b want %b at %0t", bus.INT, m_int, $time); end
    checks++;
    if (bus.pend !== m_pend_v) begin errors++; $display("FAIL pend: got %b want %b at %0t", bus.pend, m_pend_v, $time); end
    if (bus.INT === 1'b1 && int_prev !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL unexpected_int: got INTV %h with no expected entry at %0t", bus.INTV, $time); end
      else begin
        e = exp_q.pop_front();
        if ({bus.int_pri, bus.INTV} !== e) begin
          errors++;
          $display("FAIL vector: got pri %0d vec %h want pri %0d vec %h at %0t", bus.int_pri, bus.INTV, e[PW+VW-1:VW], e[VW-1:0], $time);
        end
      end
    end
    int_prev <= bus.INT;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    bus.irq_in = '1; bus.src_en = '1; bus.cur_pri = '0; bus.int_ack = 1'b0;
    set_src(0, 2, 'h10); set_src(1, 4, 'h80); set_src(2, 5, 'h30); set_src(3, 5, 'h40);
    m_pend_v = '0; m_int = 0;
    step(3);
    checks++;
    if (bus.INTV !== '0 || bus.int_pri !== '0) begin
      errors++; $display("FAIL reset_regs: got INTV %h int_pri %0d want 0 0", bus.INTV, bus.int_pri);
    end
    reset = 1'b0;
    step(3);
    bus.irq_in = '0; step(2);
    bus.irq_in[1] = 1'b1; step(3); ack(); step(3);
    bus.irq_in = 4'b1101; step(3); ack(); step(3); ack(); step(3); ack(); step(3);
    bus.irq_in = '0; set_src(0, 3, 'h11); bus.cur_pri = 3'd3; step();
    bus.irq_in[0] = 1'b1; step(4); bus.cur_pri = 3'd2; step(2); ack(); step(2);
    bus.cur_pri = '0; bus.irq_in = '0; step();
    bus.irq_in[1] = 1'b1; step(3); bus.cur_pri = 3'd7; step(2); bus.cur_pri = '0; step(3); ack(); step(2);
    bus.irq_in[1] = 1'b0; step();
    bus.irq_in[1] = 1'b1; step(3); bus.irq_in[1] = 1'b0; step();
    bus.irq_in[1] = 1'b1; ack(); step(4); ack(); step(2);
    bus.src_en[1] = 1'b0; bus.irq_in = '0; step(); bus.irq_in[1] = 1'b1; step(3); bus.src_en[1] = 1'b1; step(2);
    bus.irq_in = '0; step();
    bus.irq_in[2] = 1'b1; step(3);
    reset = 1'b1; bus.int_ack = 1'b1; step(); reset = 1'b0; bus.int_ack = 1'b0; step(3);
    ack(); step(2);
    for (int c = 0; c < 3000; c++) begin
      if (c % 97 == 0)
        for (int i = 0; i < N; i++) set_src(i, $urandom_range(0, 7), $urandom_range(0, 255));
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) bus.irq_in[i] = ~bus.irq_in[i];
      if ($urandom_range(0, 19) == 0) bus.src_en = N'($urandom);
      if ($urandom_range(0, 29) == 0) bus.cur_pri = PW'($urandom_range(0, 7));
      bus.int_ack = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    bus.int_ack = 1'b0; reset = 1'b0;
    step(3);
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: got %0d unmatched expected interrupts want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
